// File: rtl/tdc_pkg.sv
// Shared constants, field-width helpers and FSM state encoding for the TDC event arbiter.
package tdc_pkg;
  localparam int NCH_DEF = 4;
  localparam int CW_DEF  = 16;

  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic int idx_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Event word layout, MSB first: {channel, edge (1=rise), coarse time}.
  function automatic int data_w(input int nch, input int cw);
    return idx_w(nch) + 1 + cw;
  endfunction
endpackage

// File: rtl/tdc_event_arbiter_if.sv
// Event output handshake between the arbiter and its downstream consumer.
// A word transfers on a clock edge where valid and ready are both high; while valid is
// high and ready is low, valid and data hold steady. Ready may change freely.
interface tdc_event_if
  import tdc_pkg::*;
#(
  parameter int DW = data_w(NCH_DEF, CW_DEF)
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/tdc_out_reg.sv
// Output holding register: loads on grant, otherwise clears valid once the word is taken.
module tdc_out_reg
  import tdc_pkg::*;
#(
  parameter int DW = data_w(NCH_DEF, CW_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  tdc_event_if.master   out
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out.valid <= 1'b0;
      out.data  <= '0;
    end else if (load) begin
      out.valid <= 1'b1;
      out.data  <= load_data;
    end else if (out.ready) begin
      out.valid <= 1'b0;
    end
  end
endmodule

// File: rtl/tdc_rr_arbiter.sv
// Round-robin picker: first requesting channel after ptr, wrapping modulo N (N a power of two).
module tdc_rr_arbiter
  import tdc_pkg::*;
#(
  parameter int N  = NCH_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    // k == N lands back on ptr itself, so the last granted channel is checked last.
    for (int k = 1; k <= N; k++) begin
      cand = ptr + IW'(k);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
endmodule

// File: rtl/tdc_event_arbiter.sv
// Multi-channel TDC front end: per-channel single-slot event capture with coarse timestamps,
// round-robin merge into one valid/ready stream, run control via start/stop/window.
module tdc_event_arbiter
  import tdc_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic                        iClk,
  input  logic                        iRstn,
  input  logic                        iStart,
  input  logic                        iStop,
  input  logic [CW-1:0]               iWindow,
  input  logic [NCH-1:0]              iRise,
  input  logic [NCH-1:0]              iFall,
  input  logic                        iReady,
  output logic                        oValid,
  output logic [data_w(NCH, CW)-1:0]  oData,
  output logic                        oBusy,
  output logic                        oWrap,
  output logic [NCH-1:0]              oOvf
);
  localparam int IW = idx_w(NCH);
  localparam int DW = data_w(NCH, CW);

  state_t          state;
  logic [CW-1:0]   coarse;
  logic [CW-1:0]   win_last;
  logic [NCH-1:0]  pend;
  logic [NCH-1:0]  pend_rise;
  logic [CW-1:0]   pend_time [NCH];
  logic [IW-1:0]   rr_ptr;

  logic            run;
  logic            start_run;
  logic            end_run;
  logic            fire;
  logic            do_grant;
  logic [NCH-1:0]  gnt_oh;
  logic [NCH-1:0]  slot_free;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [DW-1:0]   load_data;

  tdc_event_if #(.DW(DW)) evt ();

  assign evt.ready = iReady;
  assign oValid    = evt.valid;
  assign oData     = evt.data;
  assign oBusy     = (state != ST_IDLE);

  assign run       = (state == ST_RUN);
  assign start_run = (state == ST_IDLE) && iStart;
  assign win_last  = iWindow - CW'(1);
  assign end_run   = run && (iStop || ((iWindow != '0) && (coarse == win_last)));

  // A new grant may only overwrite the output word once the current one is gone or leaving.
  assign fire      = !evt.valid || evt.ready;
  assign do_grant  = fire && gnt_any;
  assign slot_free = do_grant ? gnt_oh : '0;
  assign load_data = {gnt_idx, pend_rise[gnt_idx], pend_time[gnt_idx]};

  tdc_rr_arbiter #(.N(NCH), .IW(IW)) u_rr (
    .req (pend),
    .ptr (rr_ptr),
    .gnt (gnt_oh),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  tdc_out_reg #(.DW(DW)) u_out (
    .clk       (iClk),
    .rst_n     (iRstn),
    .load      (do_grant),
    .load_data (load_data),
    .out       (evt.master)
  );

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state  <= ST_IDLE;
      coarse <= '0;
      oWrap  <= 1'b0;
    end else begin
      oWrap <= run && (coarse == '1);
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            state  <= ST_RUN;
            coarse <= '0;
          end
        end
        ST_RUN: begin
          coarse <= coarse + CW'(1);
          if (end_run) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((pend == '0) && !evt.valid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A slot granted this cycle counts as free, so a same-cycle event recaptures into it.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      pend      <= '0;
      pend_rise <= '0;
      oOvf      <= '0;
      for (int i = 0; i < NCH; i++) pend_time[i] <= '0;
    end else begin
      if (start_run) oOvf <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (run && (iRise[i] || iFall[i])) begin
          if (pend[i] && !slot_free[i]) begin
            oOvf[i] <= 1'b1;
          end else begin
            pend[i]      <= 1'b1;
            pend_rise[i] <= iRise[i];
            pend_time[i] <= coarse;
            if (iRise[i] && iFall[i]) oOvf[i] <= 1'b1;
          end
        end else if (slot_free[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) rr_ptr <= IW'(NCH - 1);
    else if (do_grant) rr_ptr <= gnt_idx;
  end
endmodule

// File: tb/tb_tdc_event_arbiter.sv
// Bench for tdc_event_arbiter: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of runs, slots and round-robin output order.
module tb_tdc_event_arbiter;
  import tdc_pkg::*;

  localparam int NCH  = 4;
  localparam int CW   = 16;
  localparam int DW   = data_w(NCH, CW);
  localparam int SCW  = 4;
  localparam int SDW  = data_w(NCH, SCW);
  localparam int CMOD = 1 << CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT hookup ----------------
  logic           start, stop, ready;
  logic [CW-1:0]  window;
  logic [NCH-1:0] rise, fall;
  logic           busy, wrap;
  logic [NCH-1:0] ovf;

  tdc_event_if #(.DW(DW)) ev ();
  assign ev.ready = ready;

  tdc_event_arbiter #(.NCH(NCH), .CW(CW)) dut (
    .iClk(clk), .iRstn(rst_n), .iStart(start), .iStop(stop), .iWindow(window),
    .iRise(rise), .iFall(fall), .iReady(ev.ready), .oValid(ev.valid), .oData(ev.data),
    .oBusy(busy), .oWrap(wrap), .oOvf(ovf)
  );

  logic           s_start, s_stop, s_valid, s_busy, s_wrap;
  logic [SDW-1:0] s_data;
  logic [NCH-1:0] s_ovf;

  tdc_event_arbiter #(.NCH(NCH), .CW(SCW)) dut_small (
    .iClk(clk), .iRstn(rst_n), .iStart(s_start), .iStop(s_stop), .iWindow(4'd0),
    .iRise(4'b0000), .iFall(4'b0000), .iReady(1'b1), .oValid(s_valid), .oData(s_data),
    .oBusy(s_busy), .oWrap(s_wrap), .oOvf(s_ovf)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int             m_state;   // 0 idle, 1 run, 2 drain
  int             m_coarse;
  bit             m_pend [NCH];
  bit             m_rise [NCH];
  int             m_time [NCH];
  bit [NCH-1:0]   m_ovf;
  bit             m_valid;
  logic [DW-1:0]  m_data;
  int             m_last;
  bit             m_wrap;
  logic [DW-1:0]  exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    int g, c;
    bit fire, was_empty;
    if (!rst_n) begin
      m_state = 0; m_coarse = 0; m_ovf = '0; m_valid = 0; m_data = '0;
      m_last = NCH - 1; m_wrap = 0;
      for (int i = 0; i < NCH; i++) begin m_pend[i] = 0; m_rise[i] = 0; m_time[i] = 0; end
      exp_q.delete();
    end else begin
      fire = !m_valid || ready;
      was_empty = !m_valid;
      for (int i = 0; i < NCH; i++) if (m_pend[i]) was_empty = 0;
      g = -1;
      if (fire) begin
        for (int k = 1; k <= NCH; k++) begin
          c = (m_last + k) % NCH;
          if (g < 0 && m_pend[c]) g = c;
        end
      end
      if (g >= 0) begin
        m_data  = DW'(g * (1 << (CW + 1)) + int'(m_rise[g]) * (1 << CW) + m_time[g]);
        m_valid = 1;
        m_last  = g;
        m_pend[g] = 0;
        exp_q.push_back(m_data);
      end else if (ready) begin
        m_valid = 0;
      end
      m_wrap = (m_state == 1) && (m_coarse == CMOD - 1);
      if (m_state == 1) begin
        for (int i = 0; i < NCH; i++) begin
          if (rise[i] || fall[i]) begin
            if (m_pend[i]) m_ovf[i] = 1;
            else begin
              m_pend[i] = 1; m_rise[i] = rise[i]; m_time[i] = m_coarse;
              if (rise[i] && fall[i]) m_ovf[i] = 1;
            end
          end
        end
      end
      case (m_state)
        0: if (start) begin m_state = 1; m_coarse = 0; m_ovf = '0; end
        1: begin
          if (stop || (window != 0 && m_coarse == int'(window) - 1)) m_state = 2;
          m_coarse = (m_coarse + 1) % CMOD;
        end
        default: if (was_empty) m_state = 0;
      endcase
    end
  end

  // Scoreboard: every cycle against the model, and each accepted word against exp_q.
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("valid", 64'(ev.valid), 64'(m_valid));
      if (m_valid) check_eq("data", 64'(ev.data), 64'(m_data));
      check_eq("busy", 64'(busy), 64'(m_state != 0));
      check_eq("ovf", 64'(ovf), 64'(m_ovf));
      check_eq("wrap", 64'(wrap), 64'(m_wrap));
      if (ev.valid && ready) begin
        if (exp_q.size() == 0) check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
        else check_eq("sb_data", 64'(ev.data), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; rise = '0; fall = '0; s_start = 0; s_stop = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    ready = 1;
    window = '0;
    repeat (2) tick();
    rst_n = 1;
    tick();
  endtask

  task automatic begin_run();
    start = 1;
    tick();
    start = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wraps, wrap_at;
    idle_inputs();
    ready = 1;
    window = '0;

    // reset state
    do_reset();
    check_eq("rst_valid", 64'(ev.valid), 64'd0);
    check_eq("rst_data", 64'(ev.data), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ovf", 64'(ovf), 64'd0);
    check_eq("rst_wrap", 64'(wrap), 64'd0);

    // single rise on channel 2 at coarse 5, two-cycle latency
    do_reset();
    begin_run();
    repeat (5) tick();
    rise = 4'b0100;
    tick();
    rise = '0;
    check_eq("t1_lat1", 64'(ev.valid), 64'd0);
    tick();
    check_eq("t1_valid", 64'(ev.valid), 64'd1);
    check_eq("t1_data", 64'(ev.data), 64'({2'd2, 1'b1, 16'd5}));

    // all four channels at once come out 0,1,2,3 with the same coarse time
    do_reset();
    begin_run();
    rise = 4'b1111;
    tick();
    rise = '0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check_eq($sformatf("t2_valid%0d", j), 64'(ev.valid), 64'd1);
      check_eq($sformatf("t2_data%0d", j), 64'(ev.data), 64'({2'(j), 1'b1, 16'd0}));
    end

    // stalled output: pending fall on ch1 held, second fall dropped
    do_reset();
    ready = 0;
    begin_run();
    rise = 4'b0001;
    tick();
    rise = '0;
    tick();
    fall = 4'b0010;
    tick();
    fall = '0;
    tick();
    tick();
    fall = 4'b0010;
    tick();
    fall = '0;
    check_eq("t3_ovf", 64'(ovf), 64'b0010);
    check_eq("t3_hold_valid", 64'(ev.valid), 64'd1);
    check_eq("t3_hold_data", 64'(ev.data), 64'({2'd0, 1'b1, 16'd0}));
    ready = 1;
    tick();
    check_eq("t3_first_fall", 64'(ev.data), 64'({2'd1, 1'b0, 16'd2}));
    tick();
    check_eq("t3_drained", 64'(ev.valid), 64'd0);
    check_eq("t3_ovf_sticky", 64'(ovf), 64'b0010);

    // window of 10: busy through RUN and one DRAIN cycle, events in DRAIN ignored
    do_reset();
    window = 16'd10;
    begin_run();
    for (int k = 0; k <= 10; k++) begin
      check_eq($sformatf("t4_busy%0d", k), 64'(busy), 64'd1);
      if (k < 10) tick();
    end
    rise = 4'b1000;
    tick();
    rise = '0;
    check_eq("t4_idle", 64'(busy), 64'd0);
    tick();
    check_eq("t4_no_event", 64'(ev.valid), 64'd0);
    check_eq("t4_no_ovf", 64'(ovf), 64'd0);

    // 4-bit counter, unlimited window: exactly one wrap, 16 cycles into the run
    do_reset();
    s_start = 1;
    tick();
    s_start = 0;
    wraps = 0;
    wrap_at = -1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (s_wrap) begin wraps++; wrap_at = k; end
    end
    s_stop = 1;
    tick();
    s_stop = 0;
    tick();
    check_eq("t5_wrap_count", 64'(wraps), 64'd1);
    check_eq("t5_wrap_at", 64'(wrap_at), 64'd16);
    check_eq("t5_idle", 64'(s_busy), 64'd0);
    check_eq("t5_valid", 64'(s_valid), 64'd0);
    check_eq("t5_data", 64'(s_data), 64'd0);
    check_eq("t5_ovf", 64'(s_ovf), 64'd0);

    // asynchronous reset with a word out and two slots pending
    do_reset();
    ready = 0;
    begin_run();
    rise = 4'b0111;
    tick();
    rise = '0;
    tick();
    check_eq("t6_pre_valid", 64'(ev.valid), 64'd1);
    #2 rst_n = 0;
    #1;
    check_eq("t6_valid", 64'(ev.valid), 64'd0);
    check_eq("t6_data", 64'(ev.data), 64'd0);
    check_eq("t6_busy", 64'(busy), 64'd0);
    check_eq("t6_ovf", 64'(ovf), 64'd0);
    check_eq("t6_wrap", 64'(wrap), 64'd0);
    tick();
    rst_n = 1;
    ready = 1;
    tick();
    begin_run();
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq($sformatf("t6_quiet%0d", k), 64'(ev.valid), 64'd0);
    end

    // random traffic against the model
    do_reset();
    for (int r = 0; r < 1500; r++) begin
      idle_inputs();
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 30) == 0) start = 1;
      if ($urandom_range(0, 60) == 0) stop = 1;
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(0, 9) == 0) rise[ch] = 1;
        if ($urandom_range(0, 9) == 0) fall[ch] = 1;
      end
      if ($urandom_range(0, 150) == 0)
        window = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(3, 40));
      tick();
    end
    idle_inputs();
    ready = 1;
    stop = 1;
    tick();
    stop = 0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tdc_event_arbiter.md
TDC_EVENT_ARBITER -- requirements
Module: tdc_event_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4, number of edge-detector channels (power of two, 2..8).
REQ-002 SHALL have parameter CW, default 16, coarse-timestamp width.
REQ-003 SHALL have port iClk, input, 1, single clock for all logic.
REQ-004 SHALL have port iRstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port iStart, input, 1, one-cycle run-start pulse.
REQ-006 SHALL have port iStop, input, 1, one-cycle run-stop pulse.
REQ-007 SHALL have port iWindow, input, CW, run length in cycles; 0 means unlimited.
REQ-008 SHALL have port iRise, input, NCH, per-channel rising-edge pulses.
REQ-009 SHALL have port iFall, input, NCH, per-channel falling-edge pulses.
REQ-010 SHALL have port iReady, input, 1, downstream accepts oData.
REQ-011 SHALL have port oValid, output, 1, oData holds an event.
REQ-012 SHALL have port oData, output, log2(NCH)+1+CW, {channel, edge (1=rise), coarse time}.
REQ-013 SHALL have port oBusy, output, 1, state is not IDLE.
REQ-014 SHALL have port oWrap, output, 1, one-cycle pulse when the coarse counter wraps.
REQ-015 SHALL have port oOvf, output, NCH, sticky per-channel lost-event flags.

Function
REQ-016 SHALL implement FSM IDLE, RUN, DRAIN: IDLE->RUN on iStart; RUN->DRAIN on iStop or coarse==iWindow-1 (iWindow!=0); DRAIN->IDLE when no pending events and oValid==0.
REQ-017 SHALL clear coarse counter and oOvf on the IDLE->RUN transition; counter increments by 1 every RUN cycle, holds otherwise.
REQ-018 SHALL wrap coarse counter modulo 2^CW and pulse oWrap in the cycle it goes from all-ones to zero.
REQ-019 SHALL ignore iStart outside IDLE and iStop outside RUN; iStart and iStop together in IDLE enter RUN.
REQ-020 SHALL accept iRise/iFall only in RUN; events in IDLE/DRAIN are discarded without setting oOvf.
REQ-021 SHALL hold one pending slot per channel capturing edge type and current coarse value in the event cycle (pending visible next cycle).
REQ-022 SHALL, on an event to a channel whose slot is pending and not granted that cycle, drop the new event and set that channel's oOvf bit.
REQ-023 SHALL, on iRise and iFall together on one channel, capture rise, drop fall and set oOvf bit.
REQ-024 SHALL grant one pending channel per cycle round-robin, search starting at last-granted+1 modulo NCH; pointer resets to NCH-1 (channel 0 first).
REQ-025 SHALL grant only when oValid==0 or (oValid and iReady); grant loads oData and sets oValid next cycle and frees the slot, which may recapture in that same cycle.
REQ-026 SHALL hold oValid and oData stable until iReady; oValid drops after acceptance unless a new grant occurs the same cycle.
REQ-027 SHALL give minimum latency of 2 cycles from event pulse to oValid.
REQ-028 SHALL keep arbitrating pending events in DRAIN.

Reset
REQ-029 SHALL asynchronously on iRstn low force: state IDLE, coarse 0, all slots empty, oValid 0, oData 0, oBusy 0, oWrap 0, oOvf 0, RR pointer NCH-1.
REQ-030 SHALL release reset with first active edge of iClk after iRstn rises; reset mid-run discards all pending data.

Structure
REQ-031 SHALL place NCH, CW defaults, data-field widths and the FSM state type in shared package tdc_pkg.
REQ-032 SHALL implement round-robin selection as sub-module tdc_rr_arbiter (request vector, pointer -> one-hot grant, index).

Verification
REQ-033 SHALL test: iStart, iRise[2] at coarse 5, iReady=1 -> oValid two cycles later, oData={2,1,5}.
REQ-034 SHALL test: iRise on all 4 channels same cycle, iReady=1 -> four consecutive outputs, channels 0,1,2,3, identical coarse.
REQ-035 SHALL test: iReady=0, iFall[1] twice 3 cycles apart -> first held stable, second dropped, oOvf=4'b0010.
REQ-036 SHALL test: iWindow=10, iStart, no iStop -> RUN for 10 cycles, DRAIN, IDLE, oBusy falls.
REQ-037 SHALL test: CW=4, iWindow=0, run 16 cycles -> oWrap pulses once as counter goes 15->0.
REQ-038 SHALL test: iRstn low while oValid=1 and 2 slots pending -> all outputs 0 immediately, no events emitted after release.
